// File: rtl/polar_fg_sequencer_if.sv
// Bundle between the F/G/R sequencer and its surroundings: the command port,
// the LLR scratch RAM read/write ports and the polar unit operand/result port.
// Modport master is the sequencer's view, slave is the environment's view.
interface polar_fg_sequencer_if #(
  parameter int QTF_SIZE = 8,
  parameter int LOG_MAXN = 5,
  parameter int ADDR_W   = 8
);
  // command port
  logic                     cmd_valid_i;
  logic                     cmd_ready_o;
  logic [1:0]               cmd_op_i;
  logic [LOG_MAXN:0]        cmd_len_i;
  logic [ADDR_W-1:0]        cmd_src_a_i;
  logic [ADDR_W-1:0]        cmd_src_b_i;
  logic [ADDR_W-1:0]        cmd_dst_i;
  logic [2**LOG_MAXN-1:0]   cmd_bits_i;
  // scratch RAM
  logic                     rd_en_o;
  logic [ADDR_W-1:0]        rd_addr_o;
  logic [QTF_SIZE-1:0]      rd_data_i;
  logic                     wr_en_o;
  logic [ADDR_W-1:0]        wr_addr_o;
  logic [QTF_SIZE-1:0]      wr_data_o;
  // polar unit
  logic [1:0]               pu_op_o;
  logic [QTF_SIZE-1:0]      pu_a_o;
  logic [QTF_SIZE-1:0]      pu_b_o;
  logic [7:0]               pu_imm_o;
  logic [QTF_SIZE-1:0]      pu_result_i;
  // status
  logic                     busy_o;
  logic                     done_o;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_len_i, cmd_src_a_i, cmd_src_b_i, cmd_dst_i, cmd_bits_i,
    output cmd_ready_o,
    output rd_en_o, rd_addr_o, input rd_data_i,
    output wr_en_o, wr_addr_o, wr_data_o,
    output pu_op_o, pu_a_o, pu_b_o, pu_imm_o, input pu_result_i,
    output busy_o, done_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_len_i, cmd_src_a_i, cmd_src_b_i, cmd_dst_i, cmd_bits_i,
    input  cmd_ready_o,
    input  rd_en_o, rd_addr_o, output rd_data_i,
    input  wr_en_o, wr_addr_o, wr_data_o,
    input  pu_op_o, pu_a_o, pu_b_o, pu_imm_o, output pu_result_i,
    input  busy_o, done_o
  );
endinterface

// File: rtl/polar_fg_sequencer.sv
// Purpose: steps the shared polar F/G/R unit over one LLR vector from scratch RAM, writing results back.
// Latency: F/G 3 cycles per element, R 2; done_o pulses at accept+1+k*len.
// Backpressure: one command at a time; cmd_ready_o is high only in IDLE (and low during reset).
// Ports: clk_i/rst_i (sync, active-high) plus bus (master view): command, RAM rd/wr, polar unit, busy/done.
module polar_fg_sequencer #(
  parameter int QTF_SIZE = 8,
  parameter int LOG_MAXN = 5,
  parameter int ADDR_W   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  polar_fg_sequencer_if.master  bus
);

  localparam logic [LOG_MAXN:0] MAXN_L = {1'b1, {LOG_MAXN{1'b0}}};
  localparam logic [LOG_MAXN:0] ONE_I  = {{LOG_MAXN{1'b0}}, 1'b1};
  localparam logic [1:0] OP_G   = 2'd1;
  localparam logic [1:0] OP_R   = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_DONE} state_t;

  state_t                  r_state;
  logic [1:0]              r_op;
  logic [LOG_MAXN:0]       r_len;
  logic [LOG_MAXN:0]       r_i;
  logic [ADDR_W-1:0]       r_src_a;
  logic [ADDR_W-1:0]       r_src_b;
  logic [ADDR_W-1:0]       r_dst;
  logic [2**LOG_MAXN-1:0]  r_bits;
  logic [QTF_SIZE-1:0]     r_a_q;
  logic                    r_rd_en;
  logic [ADDR_W-1:0]       r_rd_addr;
  logic                    r_wr_en;
  logic [ADDR_W-1:0]       r_wr_addr;
  logic [1:0]              r_pu_op;
  logic [7:0]              r_pu_imm;
  logic                    r_busy;
  logic                    r_done;

  logic [LOG_MAXN:0]       w_len_clamped;
  logic [LOG_MAXN:0]       w_i_next;
  logic [ADDR_W-1:0]       w_i_off;
  logic [ADDR_W-1:0]       w_i_next_off;
  logic                    w_bit;
  logic                    w_last;
  logic [QTF_SIZE-1:0]     w_pu_a;
  logic [QTF_SIZE-1:0]     w_pu_b;
  logic [QTF_SIZE-1:0]     w_wr_data;

  assign w_len_clamped = (bus.cmd_len_i > MAXN_L) ? MAXN_L : bus.cmd_len_i;
  assign w_i_next      = r_i + ONE_I;
  // base+i is taken modulo 2**ADDR_W; wrap-around is intentional
  assign w_i_off       = ADDR_W'(r_i);
  assign w_i_next_off  = ADDR_W'(w_i_next);
  // r_i never reaches MAXN while an element is in flight, so the low bits index r_bits
  assign w_bit         = r_bits[r_i[LOG_MAXN-1:0]];
  assign w_last        = (w_i_next == r_len);

  // Operand b and the write data come straight from RAM / unit in the EXEC cycle,
  // so these paths are combinational; everything else is registered.
  always_comb begin
    w_pu_a    = '0;
    w_pu_b    = '0;
    w_wr_data = '0;
    if (r_state == S_EXEC) begin
      w_wr_data = bus.pu_result_i;
      if (r_op == OP_R) begin
        w_pu_a = bus.rd_data_i;
        w_pu_b = {{(QTF_SIZE-1){1'b0}}, w_bit};
      end else begin
        w_pu_a = r_a_q;
        w_pu_b = bus.rd_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_len     <= '0;
      r_i       <= '0;
      r_src_a   <= '0;
      r_src_b   <= '0;
      r_dst     <= '0;
      r_bits    <= '0;
      r_a_q     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_pu_op   <= '0;
      r_pu_imm  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid_i) begin
            r_op    <= bus.cmd_op_i;
            r_len   <= w_len_clamped;
            r_src_a <= bus.cmd_src_a_i;
            r_src_b <= bus.cmd_src_b_i;
            r_dst   <= bus.cmd_dst_i;
            r_bits  <= bus.cmd_bits_i;
            r_i     <= '0;
            // empty or reserved commands complete without touching RAM
            if (w_len_clamped == '0 || bus.cmd_op_i == OP_RSV) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_RD_A;
              r_busy    <= 1'b1;
              r_pu_op   <= bus.cmd_op_i;
              r_rd_en   <= 1'b1;
              r_rd_addr <= bus.cmd_src_a_i;
            end
          end
        end
        S_RD_A: begin
          if (r_op == OP_R) begin
            // R has a single operand: its data arrives in EXEC
            r_state   <= S_EXEC;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_dst + w_i_off;
            r_pu_imm  <= 8'h00;
          end else begin
            r_state   <= S_RD_B;
            r_rd_addr <= r_src_b + w_i_off;
          end
        end
        S_RD_B: begin
          r_a_q     <= bus.rd_data_i;
          r_state   <= S_EXEC;
          r_rd_en   <= 1'b0;
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_dst + w_i_off;
          // G picks a+b or b-a from the partial-sum bit
          r_pu_imm  <= (r_op == OP_G && w_bit) ? 8'h01 : 8'h00;
        end
        S_EXEC: begin
          r_wr_en  <= 1'b0;
          r_pu_imm <= 8'h00;
          r_i      <= w_i_next;
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pu_op <= '0;
          end else begin
            r_state   <= S_RD_A;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_src_a + w_i_next_off;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o = (r_state == S_IDLE) && !rst_i;
  assign bus.rd_en_o     = r_rd_en;
  assign bus.rd_addr_o   = r_rd_addr;
  assign bus.wr_en_o     = r_wr_en;
  assign bus.wr_addr_o   = r_wr_addr;
  assign bus.wr_data_o   = w_wr_data;
  assign bus.pu_op_o     = r_pu_op;
  assign bus.pu_a_o      = w_pu_a;
  assign bus.pu_b_o      = w_pu_b;
  assign bus.pu_imm_o    = r_pu_imm;
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;

endmodule

// File: doc/polar_fg_sequencer.md
Name: polar_fg_sequencer

Overview:
- Sequences the shared polar F/G/R processing unit of the integer ALU over a vector of LLRs for one successive-cancellation decoder node stage.
- Accepts one vector command, reads operand pairs from an LLR scratch memory, and drives the unit's operator, operands and immediate.
- Writes each element's result back to the scratch memory, then pulses done.
- Sits between the decoder control/CSR front end and the polar unit plus LLR scratch RAM.

Parameters:
QTF_SIZE, 8, LLR width in bits (two's complement)
LOG_MAXN, 5, log2 of max elements per command (MAXN = 32)
ADDR_W, 8, scratch memory address width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready, high only in IDLE
cmd_op_i  in  2  0=F, 1=G, 2=R, 3=reserved
cmd_len_i  in  LOG_MAXN+1  element count; values above MAXN are clamped to MAXN
cmd_src_a_i  in  ADDR_W  base address of operand a vector
cmd_src_b_i  in  ADDR_W  base address of operand b vector (ignored for R)
cmd_dst_i  in  ADDR_W  base address of result vector
cmd_bits_i  in  2**LOG_MAXN  per-element bit: beta (partial sum) for G, frozen flag for R
rd_en_o  out  1  scratch read strobe
rd_addr_o  out  ADDR_W  read address
rd_data_i  in  QTF_SIZE  read data, valid exactly 1 cycle after rd_en_o
wr_en_o  out  1  scratch write strobe
wr_addr_o  out  ADDR_W  write address
wr_data_o  out  QTF_SIZE  write data
pu_op_o  out  2  operator to polar unit, same encoding as cmd_op_i
pu_a_o  out  QTF_SIZE  unit operand a
pu_b_o  out  QTF_SIZE  unit operand b
pu_imm_o  out  8  unit immediate; 0 selects a+b, nonzero selects b-a
pu_result_i  in  QTF_SIZE  unit result, combinational in the same cycle
busy_o  out  1  command in progress
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_i high at an edge):
  - FSM goes to IDLE and the element counter i clears.
  - rd_en_o, wr_en_o, done_o and busy_o are 0; pu_*, rd_addr_o, wr_addr_o and wr_data_o are 0.
  - cmd_ready_o is 0 while rst_i is high and 1 in IDLE otherwise.
  - Reset mid-command aborts it: no further reads or writes and no done_o.
- Accept: cmd_valid_i & cmd_ready_o at an edge.
  - Latches op, clamped len, bases and the bits vector; i=0.
  - Then moves to RD_A, or directly to DONE if len==0 or op==3.
  - cmd_* may change freely after accept.
- FSM states: IDLE, RD_A, RD_B, EXEC, DONE.
  - RD_A: rd_en_o=1, rd_addr_o=src_a+i. Next state is RD_B for F/G, EXEC for R.
  - RD_B (F/G only): a_q <= rd_data_i; rd_en_o=1, rd_addr_o=src_b+i; next EXEC.
  - EXEC (F/G): pu_a_o=a_q, pu_b_o=rd_data_i.
  - EXEC (R): pu_a_o=rd_data_i, pu_b_o=zero-extended bits[i].
  - EXEC (G): pu_imm_o = bits[i] ? 8'h01 : 8'h00. For F/R, pu_imm_o=0.
  - EXEC (all ops): wr_en_o=1, wr_addr_o=dst+i, wr_data_o=pu_result_i; i <= i+1. If i+1==len go to DONE, else RD_A.
  - DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE. cmd_ready_o is 0 in DONE.
- pu_op_o equals the latched op in RD_A/RD_B/EXEC and is 0 elsewhere.
- busy_o=1 in RD_A, RD_B and EXEC.
- Latency: F/G take 3 cycles per element, R takes 2. done_o fires at accept+1+k·len (k=3 or 2).
- Address arithmetic is modulo 2**ADDR_W; base+i wraps silently.
- Each element is written exactly once, in ascending i. There is no read-after-write hazard check; src/dst overlap is allowed because element i is read before it is written.
- A cmd_valid_i held high during DONE is not accepted until the following IDLE cycle.

Test Plan:
- F, len=1, a=0xFB(-5), b=0x03, bench unit model: accept at cycle 0 -> reads at cycles 1 (src_a) and 2 (src_b); cycle 3 has wr_en_o=1, pu_op_o=0, pu_a_o=0xFB, pu_b_o=0x03, write data 0xFD; done_o at cycle 4.
- G, len=2, a={100,100}, b={50,50}, bits=2'b10 -> pu_imm_o 0x00 then 0x01; writes 0x7F (saturated) then 0xCE (-50); done_o at cycle 7.
- R, len=4, a={0x80,0x80,0x05,0x05}, bits=4'b0010 -> no src_b reads; writes 1,0,0,0; done_o at cycle 9; busy_o high for cycles 1-8.
- Wrap: F, src_a=0xFE, src_b=0x10, dst=0xFF, len=3 -> a reads at FE,FF,00; writes at FF,00,01.
- len=0 and op=3 -> done_o at cycle 1, no rd_en_o/wr_en_o; len=40 is clamped to 32 (96 EXEC-cycle span, done_o at cycle 97).
- rst_i asserted at cycle 5 of a len=4 F command -> no writes after cycle 5, no done_o, cmd_ready_o=1 the cycle after reset deasserts, and a new command is accepted normally.
